// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline control slice.
// Optional feature macro: PIPE_PERF_EN (builds the stall/flush performance counters).
package cpu_types_pkg;

   // Control state machine states
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } ctrl_state_t;

   localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall bundle between the pipeline stages and the control unit.
// master = stage side (drives causes, receives enables), slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             ihit;
   logic             dhit;
   logic             dmem_req;
   logic             lw_use;
   logic             branch_taken;
   logic             jump;
   logic             halt_wb;
   logic             en_ifid;
   logic             en_idex;
   logic             en_exmem;
   logic             en_memwb;
   logic             flush_ifid;
   logic             flush_idex;
   logic             pc_en;
   logic             halt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, dmem_req, lw_use, branch_taken, jump, halt_wb,
      input  en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
             pc_en, halt, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, dmem_req, lw_use, branch_taken, jump, halt_wb,
      output en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex,
             pc_en, halt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones, clears on synchronous active-low reset.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, stop at the maximum value
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller for the five-stage pipeline.
// Freezes the pipe across data-memory waits and parks it on HALT.
// Optional feature macro: PIPE_PERF_EN (stall_cnt/flush_cnt counters; tied to 0 otherwise).
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic           CLK,
   input  logic           nRST,
   pipeline_ctrl_if.slave bus
);

   ctrl_state_t stateReg;
   ctrl_state_t stateNext;
   ctrl_state_t effState;
   logic        enIfid;
   logic        enRest;
   logic        pcEn;
   logic        flIfid;
   logic        flIdex;
   logic        haltOut;

   // Next state and zero-latency enable/flush decode from state and live inputs
   always_comb begin
      // While reset is held the outputs follow the RUN rules, whatever the register holds
      effState  = nRST ? stateReg : RUN;
      stateNext = effState;
      enIfid    = 1'b0;
      enRest    = 1'b0;
      pcEn      = 1'b0;
      flIfid    = 1'b0;
      flIdex    = 1'b0;
      haltOut   = 1'b0;
      case (effState)
         RUN: begin
            if (bus.halt_wb) begin
               stateNext = HALT;
            end else if (bus.dmem_req && !bus.dhit) begin
               stateNext = DWAIT;
            end else if (bus.ihit) begin
               enIfid = 1'b1;
               enRest = 1'b1;
               pcEn   = 1'b1;
               if (bus.branch_taken) begin
                  flIfid = 1'b1;
                  flIdex = 1'b1;
               end else if (bus.lw_use) begin
                  enIfid = 1'b0;
                  pcEn   = 1'b0;
                  flIdex = 1'b1;
               end else if (bus.jump) begin
                  flIfid = 1'b1;
               end
            end
         end
         DWAIT: begin
            // halt_wb is deliberately ignored until the data access completes
            if (bus.dhit) begin
               stateNext = RUN;
               enIfid    = 1'b1;
               enRest    = 1'b1;
               pcEn      = 1'b1;
               if (bus.branch_taken) begin
                  flIfid = 1'b1;
                  flIdex = 1'b1;
               end else if (bus.lw_use) begin
                  enIfid = 1'b0;
                  pcEn   = 1'b0;
                  flIdex = 1'b1;
               end else if (bus.jump) begin
                  flIfid = 1'b1;
               end
               // Fetch not ready: advance the pipe anyway but push a bubble into ID
               if (!bus.ihit) begin
                  pcEn   = 1'b0;
                  flIfid = 1'b1;
               end
            end
         end
         HALT: begin
            haltOut = 1'b1;
         end
         default: begin
            stateNext = RUN;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         stateReg <= RUN;
      end else begin
         stateReg <= stateNext;
      end
   end

   assign bus.en_ifid    = enIfid;
   assign bus.en_idex    = enRest;
   assign bus.en_exmem   = enRest;
   assign bus.en_memwb   = enRest;
   // A flush only means something when its latch actually loads
   assign bus.flush_ifid = flIfid & enIfid;
   assign bus.flush_idex = flIdex & enRest;
   assign bus.pc_en      = pcEn;
   assign bus.halt       = haltOut;

`ifdef PIPE_PERF_EN
   logic stallInc;
   logic flushInc;

   assign stallInc = !enRest && (effState != HALT);
   assign flushInc = (flIfid & enIfid) | (flIdex & enRest);

   sat_counter #(.W(CNT_W)) stallCounter (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (stallInc),
      .count (bus.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) flushCounter (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (flushInc),
      .count (bus.flush_cnt)
   );
`else
   assign bus.stall_cnt = {CNT_W{1'b0}};
   assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control unit for the five-stage MIPS pipeline. It receives the load-use flag from the hazard unit, the branch, jump and halt indications from the stages, and the cache hit strobes. From these it drives the enable and flush inputs of the four pipeline latches, so it is the stall/flush end of the hazard path. A small state machine holds the pipeline frozen across data-memory waits and parks it permanently on halt.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (present only with PIPE_PERF_EN)

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- nRST  input  1  reset; synchronous, active-low
- ihit  input  1  instruction fetch complete this cycle
- dhit  input  1  data access complete this cycle (one-cycle pulse)
- dmem_req  input  1  MEM-stage instruction has dREN or dWEN set
- lw_use  input  1  hazard unit: ID instruction reads the rt of the load currently in EX
- branch_taken  input  1  EX-stage branch resolved taken
- jump  input  1  ID-stage J/JAL/JR decoded
- halt_wb  input  1  HALT instruction in WB
- en_ifid, en_idex, en_exmem, en_memwb  output  1 each  latch enables
- flush_ifid, flush_idex  output  1 each  load a bubble (NOP, all controls 0) into the latch
- pc_en  output  1  PC update enable
- halt  output  1  sticky halt to the system
- stall_cnt, flush_cnt  output  CNT_W each  performance counters

## Operation
- States: RUN, DWAIT, HALT. Reset state is RUN.
- Outputs are combinational from the state and the current inputs.
- RUN, evaluated in this priority order:
  1. halt_wb=1: all enables 0, pc_en 0, go to HALT.
  2. dmem_req=1 and dhit=0: all enables 0, pc_en 0, go to DWAIT.
  3. ihit=0: all enables 0, pc_en 0, stay in RUN.
  4. branch_taken=1: all enables 1, pc_en 1, flush_ifid=1, flush_idex=1.
  5. lw_use=1: en_ifid 0, pc_en 0, flush_idex 1, all other enables 1.
  6. jump=1: all enables 1, pc_en 1, flush_ifid 1.
  7. Otherwise: all enables 1, pc_en 1.
- DWAIT:
  - dhit=0: everything frozen.
  - dhit=1: apply RUN rules 4–7 and return to RUN.
    - If ihit=0 in the same cycle, the pipeline still advances, but pc_en=0 and flush_ifid=1 (a bubble enters ID).
  - halt_wb is ignored in DWAIT.
- HALT: all enables 0, pc_en 0, flush outputs 0, halt=1. HALT is left only by reset.
- Each flush output is asserted only in a cycle where its latch enable is also 1.

## Timing
- Reset, applied on any CLK edge with nRST=0, including mid-DWAIT: state RUN, counters 0, halt 0.
  - Enables follow the RUN rules combinationally, so with ihit=0 during reset all enables are 0.
- Flush/enable responses have zero latency: they are valid in the cycle the cause is asserted and are consumed on the next edge.
- A load-use hazard costs exactly one bubble. lw_use deasserts once the load reaches MEM; the hazard unit guarantees this.
- A DWAIT of N cycles without dhit freezes the pipeline for N+1 edges, counting the entry cycle.

## Configuration
- PIPE_PERF_EN defined:
  - stall_cnt increments every cycle in which en_idex=0 and the state is not HALT.
  - flush_cnt increments every cycle in which flush_ifid or flush_idex is 1 (once per cycle, even if both are set).
  - Both counters saturate at all-ones and clear on reset.
- PIPE_PERF_EN undefined: the counter registers are not built and both outputs are tied to 0.

## Structure
- Add typedef enum logic [1:0] ctrl_state_t {RUN, DWAIT, HALT} to cpu_types_pkg.
- Sub-module sat_counter (parameter W; ports CLK, nRST, inc, count) is instantiated twice under PIPE_PERF_EN.

## Test plan
- nRST=0 for 2 cycles, then ihit=1 with no hazards -> all enables and pc_en 1, halt 0, counters 0.
- lw_use=1 for 1 cycle -> en_ifid=0, pc_en=0, flush_idex=1; next cycle all enables 1; with PIPE_PERF_EN, stall_cnt=0 and flush_cnt=1.
- dmem_req=1, dhit low for 3 cycles then high -> enables 0 for 3 cycles, then 1 on the dhit cycle; state returns to RUN; stall_cnt=3.
- dhit=1 coincident with ihit=0 and branch_taken=1 in DWAIT -> all enables 1, pc_en 0, flush_ifid=1, flush_idex=1.
- halt_wb=1 -> halt=1 from the next cycle; further ihit and branch_taken inputs cause no enable; nRST=0 returns the block to RUN with halt=0.
- With CNT_W=4, force 20 stall cycles -> stall_cnt holds at 15.
